// File: rtl/cp0_register_file.sv
// Coprocessor-0 register block: BadVAddr, Count, Compare, Status, Cause and EPC,
// updated from WB-stage commits, producing mfc0 read data, redirect target and interrupt request.
module cp0_register_file #(
  parameter logic [31:0] EXCEPTION_ENTRY = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIVIDER   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        move_to_cp0,
  input  logic [4:0]  cp0_address_register,
  input  logic [2:0]  cp0_address_select,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        exception_valid,
  input  logic        eret_flush,
  input  logic [4:0]  exception_code,
  input  logic        in_delay_slot,
  input  logic [31:0] program_count,
  input  logic        is_address_fault,
  input  logic [31:0] badvaddr_value,
  input  logic [5:0]  hardware_interrupt,
  output logic [31:0] redirect_target,
  output logic        interrupt_pending
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  hw_q;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        tick_q, tick_d;

  logic [31:0] status;
  logic [31:0] cause;
  logic        count_inc;
  logic        select_ok;

  assign status    = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause     = {bd_q, ti_q, 14'b0, hw_q[5] | ti_q, hw_q[4:0], ip_sw_q, 1'b0, exccode_q, 2'b00};
  assign count_inc = (COUNT_DIVIDER == 1) ? 1'b1 : tick_q;
  assign select_ok = (cp0_address_select == 3'd0);

  always_comb begin
    read_data = '0;
    if (select_ok) begin
      case (cp0_address_register)
        ADDR_BADVADDR: read_data = badvaddr_q;
        ADDR_COUNT:    read_data = count_q;
        ADDR_COMPARE:  read_data = compare_q;
        ADDR_STATUS:   read_data = status;
        ADDR_CAUSE:    read_data = cause;
        ADDR_EPC:      read_data = epc_q;
        default:       read_data = '0;
      endcase
    end
  end

  // Redirect is held at zero while reset is asserted so an in-flight exception is dropped.
  always_comb begin
    redirect_target = '0;
    if (!reset) begin
      if (exception_valid)  redirect_target = EXCEPTION_ENTRY;
      else if (eret_flush)  redirect_target = epc_q;
    end
  end

  assign interrupt_pending = ie_q & ~exl_q & (|(cause[15:8] & im_q));

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_inc ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    tick_d     = ~tick_q;

    if ((count_q == compare_q) && (compare_q != 32'd0)) ti_d = 1'b1;

    // Exception wins over eret, which wins over mtc0; nested exceptions keep EPC/BD.
    if (exception_valid) begin
      exl_d     = 1'b1;
      exccode_d = exception_code;
      if (!exl_q) begin
        epc_d = in_delay_slot ? program_count - 32'd4 : program_count;
        bd_d  = in_delay_slot;
      end
      if (is_address_fault) badvaddr_d = badvaddr_value;
    end else if (eret_flush) begin
      exl_d = 1'b0;
    end else if (move_to_cp0 && select_ok) begin
      case (cp0_address_register)
        ADDR_COUNT:   count_d = write_data;
        ADDR_COMPARE: begin
          compare_d = write_data;
          ti_d      = 1'b0;
        end
        ADDR_STATUS: begin
          im_d  = write_data[15:8];
          exl_d = write_data[1];
          ie_d  = write_data[0];
        end
        ADDR_CAUSE:   ip_sw_d = write_data[9:8];
        ADDR_EPC:     epc_d   = write_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      hw_q       <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      hw_q       <= hardware_interrupt;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      tick_q     <= tick_d;
    end
  end

endmodule
